// File: rtl/mul_sequencer_if.sv
// mul_sequencer_if: request/response bundle for the sequential multiplier.
//   start   - request valid, qualified by ready
//   a_in    - multiplicand, sampled on accept
//   b_in    - multiplier, sampled on accept
//   ready   - a start would be accepted this cycle
//   busy    - multiply in progress
//   done    - one-cycle pulse, product valid
//   product - low N bits of a_in*b_in, held until the next done
// master: requester side; slave: multiplier side.
interface mul_sequencer_if #(
    parameter int unsigned N = 32
);
    logic         start;
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic         ready;
    logic         busy;
    logic         done;
    logic [N-1:0] product;

    modport master (
        output start, a_in, b_in,
        input  ready, busy, done, product
    );

    modport slave (
        input  start, a_in, b_in,
        output ready, busy, done, product
    );
endinterface

// File: rtl/mul_sequencer.sv
// mul_sequencer: shift-and-add multiplier built around a single shared ALU.
// Each multiplier bit costs three cycles (ACC add, SHL multiplicand, SHR
// multiplier); the loop exits as soon as the shifted multiplier reaches zero.
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous, active-high reset
//   bus - mul_sequencer_if.slave (start/a_in/b_in in, ready/busy/done/product out)
// Also holds mul_alu_pkg (ALU control encodings) and the alu used by the sequencer.

package mul_alu_pkg;
    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SLL = 2'd1,
        ALU_SRL = 2'd2
    } alu_control_t;
endpackage

// alu: N-bit add / logical shift left / logical shift right.
//   a, b     - operands (b supplies the shift amount for shifts)
//   control  - operation select
//   result   - operation result, add wraps modulo 2^N
//   zero     - result == 0
//   overflow - signed overflow of an add
module alu
    import mul_alu_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    input  alu_control_t  control,
    output logic [N-1:0]  result,
    output logic          zero,
    output logic          overflow
);
    localparam int unsigned ShW = $clog2(N);

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        unique case (control)
            ALU_ADD: begin
                result   = a + b;
                overflow = (a[N-1] == b[N-1]) && (result[N-1] != a[N-1]);
            end
            ALU_SLL: result = a << b[ShW-1:0];
            ALU_SRL: result = a >> b[ShW-1:0];
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);
endmodule

module mul_sequencer
    import mul_alu_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input logic          clk,
    input logic          rst,
    mul_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACC  = 3'd1,
        SHL  = 3'd2,
        SHR  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [N-1:0] One = N'(1);

    state_t       state_q, state_d;
    logic [N-1:0] acc_q, acc_d;
    logic [N-1:0] mcand_q, mcand_d;
    logic [N-1:0] mplier_q, mplier_d;
    logic [N-1:0] product_q, product_d;

    logic [N-1:0] alu_a, alu_b, alu_result;
    alu_control_t alu_control;
    logic         alu_zero;
    logic         alu_ovf_unused;  // adds wrap; overflow is meaningless here

    logic ready, accept;

    alu #(.N(N)) u_alu (
        .a        (alu_a),
        .b        (alu_b),
        .control  (alu_control),
        .result   (alu_result),
        .zero     (alu_zero),
        .overflow (alu_ovf_unused)
    );

    assign ready  = (state_q == IDLE) || (state_q == DONE);
    assign accept = bus.start && ready;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        product_d   = product_q;
        alu_a       = acc_q;
        alu_b       = mcand_q;
        alu_control = ALU_ADD;

        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    acc_d    = '0;
                    mcand_d  = bus.a_in;
                    mplier_d = bus.b_in;
                    if (bus.b_in == '0) begin
                        // Nothing to accumulate: go straight to DONE with a zero product.
                        state_d   = DONE;
                        product_d = '0;
                    end else begin
                        state_d = ACC;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            ACC: begin
                alu_a       = acc_q;
                alu_b       = mcand_q;
                alu_control = ALU_ADD;
                if (mplier_q[0]) begin
                    acc_d = alu_result;
                end
                state_d = SHL;
            end
            SHL: begin
                alu_a       = mcand_q;
                alu_b       = One;
                alu_control = ALU_SLL;
                mcand_d     = alu_result;
                state_d     = SHR;
            end
            SHR: begin
                alu_a       = mplier_q;
                alu_b       = One;
                alu_control = ALU_SRL;
                mplier_d    = alu_result;
                // No set bits left in the multiplier: acc already holds the product.
                if (alu_zero) begin
                    state_d   = DONE;
                    product_d = acc_q;
                end else begin
                    state_d = ACC;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            product_q <= product_d;
        end
    end

    assign bus.ready   = ready;
    assign bus.busy    = (state_q == ACC) || (state_q == SHL) || (state_q == SHR);
    assign bus.done    = (state_q == DONE);
    assign bus.product = product_q;
endmodule

// File: tb/tb_mul_sequencer.sv
module tb_mul_sequencer;
    logic clk = 1'b0;
    logic rst;

    mul_sequencer_if #(.N(32)) bus ();

    mul_sequencer #(.N(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int overlap = 0;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
        int          lat;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Reference model: plain arithmetic from the multiply rules.
    function automatic logic [31:0] model_product(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] full;
        full = {32'd0, a} * {32'd0, b};
        return full[31:0];
    endfunction

    function automatic int model_latency(input logic [31:0] b);
        int k = -1;
        for (int i = 0; i < 32; i++) if (b[i]) k = i;
        if (k < 0) return 1;
        return 3 * (k + 1) + 1;
    endfunction

    // Called right after an accept edge; walks negedges until done appears.
    task automatic measure(output logic [31:0] prod, output int lat, output int busy_n,
                           output bit seen);
        seen = 0; lat = 0; busy_n = 0; prod = '0;
        for (int n = 1; n <= 200 && !seen; n++) begin
            @(negedge clk);
            if (bus.busy && bus.ready) overlap++;
            if (bus.done) begin
                seen = 1;
                lat  = n;
                prod = bus.product;
            end else if (bus.busy) begin
                busy_n++;
            end
        end
    endtask

    task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_p, input int exp_lat);
        logic [31:0] p;
        int lat, busy_n;
        bit seen;
        @(negedge clk);
        for (int w = 0; w < 200 && !bus.ready; w++) @(negedge clk);
        check({name, "_ready"}, 64'(bus.ready), 64'd1);
        bus.start = 1'b1;
        bus.a_in  = a;
        bus.b_in  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a_in  = $urandom;
        bus.b_in  = $urandom;
        measure(p, lat, busy_n, seen);
        check({name, "_done_seen"}, 64'(seen), 64'd1);
        check({name, "_product"}, 64'(p), 64'(exp_p));
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check({name, "_busy_cycles"}, 64'(busy_n), 64'(exp_lat - 1));
        @(negedge clk);
        check({name, "_done_pulse_width"}, 64'(bus.done), 64'd0);
        check({name, "_product_held"}, 64'(bus.product), 64'(exp_p));
    endtask

    initial begin
        logic [31:0] p, a, b;
        int lat, busy_n, sh, done_seen;
        bit seen;

        vecs[0] = '{"basic_6x7",   32'd6,          32'd7,          32'd42,         10};
        vecs[1] = '{"zero_mplier", 32'd5,          32'd0,          32'd0,          1};
        vecs[2] = '{"all_ones",    32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  97};
        vecs[3] = '{"truncation",  32'h0001_0000,  32'h0001_0000,  32'h0000_0000,  52};
        vecs[4] = '{"one_x_one",   32'd1,          32'd1,          32'd1,          4};
        vecs[5] = '{"msb_mplier",  32'd3,          32'h8000_0000,  32'h8000_0000,  97};
        vecs[6] = '{"shift_by_16", 32'h1234_5678,  32'h10,         32'h2345_6780,  16};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        #2;
        check("reset_ready",   64'(bus.ready),   64'd1);
        check("reset_busy",    64'(bus.busy),    64'd0);
        check("reset_done",    64'(bus.done),    64'd0);
        check("reset_product", 64'(bus.product), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) do_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].lat);

        // Start held through the whole op; operands change while busy.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a_in  = 32'd3;
        bus.b_in  = 32'd3;
        @(posedge clk);
        #1;
        bus.a_in = 32'd9;
        bus.b_in = 32'd9;
        measure(p, lat, busy_n, seen);
        check("proto_first_seen",    64'(seen), 64'd1);
        check("proto_first_product", 64'(p),    64'd9);
        check("proto_first_latency", 64'(lat),  64'd7);
        @(posedge clk);  // accept while in DONE
        #1;
        bus.start = 1'b0;
        measure(p, lat, busy_n, seen);
        check("proto_second_seen",    64'(seen), 64'd1);
        check("proto_second_product", 64'(p),    64'd81);
        check("proto_second_latency", 64'(lat),  64'd13);

        // Asynchronous reset in the middle of 6*7.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a_in  = 32'd6;
        bus.b_in  = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        check("midop_busy_before_rst", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        #1;
        check("async_rst_busy",    64'(bus.busy),    64'd0);
        check("async_rst_ready",   64'(bus.ready),   64'd1);
        check("async_rst_done",    64'(bus.done),    64'd0);
        check("async_rst_product", 64'(bus.product), 64'd0);
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        check("rst_no_done_pulse", 64'(done_seen), 64'd0);
        do_op("after_rst_2x3", 32'd2, 32'd3, 32'd6, 7);

        // Randomized operands against the reference model.
        for (int i = 0; i < 24; i++) begin
            a  = $urandom;
            sh = $urandom_range(0, 31);
            b  = $urandom >> sh;
            if ($urandom_range(0, 7) == 0) b = '0;
            do_op("random", a, b, model_product(a, b), model_latency(b));
        end

        check("busy_ready_overlap", 64'(overlap), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 SHALL have parameter N, default 32, datapath width; only N=32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request valid; qualified by ready.
REQ-005 SHALL have port a_in  input  N  multiplicand, sampled on accept.
REQ-006 SHALL have port b_in  input  N  multiplier, sampled on accept.
REQ-007 SHALL have port ready  output  1  high when a start would be accepted this cycle.
REQ-008 SHALL have port busy  output  1  high while a multiply is in progress (ACC, SHL, SHR).
REQ-009 SHALL have port done  output  1  one-cycle pulse marking product valid.
REQ-010 SHALL have port product  output  N  low N bits of a_in*b_in, held until the next done.

Function
REQ-011 SHALL instantiate exactly one alu and perform every add and shift through it, driving control with the alu_control_t encodings ALU_ADD, ALU_SLL and ALU_SRL.
REQ-012 SHALL hold internal registers acc, mcand and mplier (N bits each) and a state register with states IDLE, ACC, SHL, SHR and DONE.
REQ-013 Accept SHALL occur on a rising edge where start=1 and ready=1; accept SHALL load acc=0, mcand=a_in and mplier=b_in.
REQ-014 ready SHALL be 1 in IDLE and DONE and 0 in ACC, SHL and SHR; start when ready=0 SHALL be ignored with no side effect.
REQ-015 On accept, next state SHALL be DONE if b_in==0, else ACC.
REQ-016 In ACC, the ALU SHALL compute acc + mcand (ALU_ADD); acc SHALL be updated only if mplier[0]=1; next state SHALL be SHL.
REQ-017 In SHL, the ALU SHALL compute mcand SLL 1 into mcand; next state SHALL be SHR.
REQ-018 In SHR, the ALU SHALL compute mplier SRL 1 into mplier; next state SHALL be DONE if the ALU zero flag is 1, else ACC.
REQ-019 Adds SHALL wrap modulo 2^N; the ALU overflow output SHALL be ignored; bits shifted out SHALL be discarded.
REQ-020 On entry to DONE, product SHALL be loaded with acc; done SHALL be 1 for exactly the one cycle spent in DONE.
REQ-021 From DONE with no accept, next state SHALL be IDLE; an accept in DONE SHALL follow REQ-013/REQ-015 directly, skipping IDLE.
REQ-022 Latency SHALL be: accept edge to done high = 1 cycle if b_in==0, else 3*(k+1)+1 cycles, where k is the index of the highest set bit of b_in.
REQ-023 In IDLE and DONE, the ALU inputs SHALL be don't-care, but no internal register other than those loaded by REQ-013/REQ-020 SHALL change.
REQ-024 The operands a_in and b_in SHALL NOT be sampled other than on an accept edge.
REQ-025 busy SHALL equal (state is ACC, SHL or SHR); busy and ready SHALL never both be 1.

Reset
REQ-026 rst=1 SHALL immediately, without waiting for clk, force state=IDLE, acc=mcand=mplier=0, product=0, done=0, busy=0 and ready=1.
REQ-027 rst asserted mid-multiply SHALL abandon the operation with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Verification
REQ-028 Basic case: a_in=6, b_in=7, start for one cycle from IDLE -> done=1 exactly 10 cycles after accept, product=42, busy high for 9 cycles.
REQ-029 Zero multiplier: a_in=5, b_in=0 -> done 1 cycle after accept, product=0, busy never high.
REQ-030 All ones: a_in=b_in=0xFFFFFFFF -> done 97 cycles after accept, product=0x00000001.
REQ-031 Truncation: a_in=b_in=0x00010000 -> done 52 cycles after accept, product=0x00000000.
REQ-032 Protocol: start=1 held with a_in=3, b_in=3, then operands changed to 9, 9 while busy -> first done gives product=9; start still high in DONE is accepted back-to-back and the second done gives product=81.
REQ-033 Reset: assert rst asynchronously 4 cycles into a_in=6, b_in=7 -> outputs reach reset values before the next clk edge, no done pulse; a new accept of 2*3 gives product=6 with done 7 cycles after accept.
